bus_arbiter: RTL and testbench

Shares the external 16-bit memory bus between the CPU core and a secondary host requester, such as a boot loader, debug monitor or DMA. It sits between the core's bus pins (address, data out, RDN, WRN0/WRN1, bus output enable) and the physical SRAM/IO bus. It stalls the core only at instruction boundaries, then runs host transfers with programmable strobe width. Core traffic passes through unchanged whenever the host does not own the bus.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_strobe_timer.sv | 37 +++
 rtl/bus_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the bus arbiter slice.
// Holds the arbiter state encoding and the widths of the strobe and burst
// counters, so the top level and the strobe timer agree on them.
package arb_pkg;

  // Who owns the memory bus, and which phase a host transfer is in
  typedef enum logic [1:0] {
    ST_CORE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_e;

  localparam int STROBE_CNT_W = 4;
  localparam int BURST_CNT_W  = 4;

endpackage

// File: rtl/arb_strobe_timer.sv
// Loadable down-counter that times the host strobe-low window.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset (count returns to 0)
//   load_i     - load load_val_i (takes priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one, saturating at 0
//   tc_o       - terminal count: the registered count is 0
module arb_strobe_timer
  import arb_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [STROBE_CNT_W-1:0] load_val_i,
  input  logic                    dec_i,
  output logic                    tc_o
);

  logic [STROBE_CNT_W-1:0] cnt_q;

  // Count register: load, decrement or hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {STROBE_CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != {STROBE_CNT_W{1'b0}})) begin
      cnt_q <= cnt_q - STROBE_CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign tc_o = (cnt_q == {STROBE_CNT_W{1'b0}});

endmodule

// File: rtl/bus_arbiter.sv
// Shares the external 16-bit memory bus between the CPU core and a host
// requester. The core is only stalled at an instruction boundary (COMMIT);
// the host then gets a SETUP / STROBE(xSTROBE_CYCLES) / RECOVER transfer.
// While the core owns the bus, MEM_* is a combinational copy of CORE_*.
//
// Optional feature: define HOST_BURST_EN to let the host chain up to
// MAX_BURST transfers under a single CORE_HOLD assertion. Without it every
// grant carries exactly one transfer.
//
// Ports:
//   CLK, RESET          - clock and synchronous active-high reset
//   COMMIT              - core is in its last instruction phase
//   CORE_*              - core bus pins (address, write data, strobes, OEN)
//   CORE_HOLD           - registered core stall while the host owns the bus
//   HOST_REQ/WR/BEN     - host request level, direction, byte enables
//   HOST_ADDR/DOUT      - host address and write data
//   HOST_ACK            - one-cycle completion pulse (RECOVER cycle)
//   HOST_DIN            - read data, held until the next ACK
//   MEM_DIN             - memory read data
//   MEM_*               - muxed physical bus
module bus_arbiter
  import arb_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int MAX_BURST     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        COMMIT,
  input  logic [15:0] CORE_ADDR,
  input  logic [15:0] CORE_DOUT,
  input  logic        CORE_RDN,
  input  logic        CORE_WRN0,
  input  logic        CORE_WRN1,
  input  logic        CORE_DBUS_OEN,
  output logic        CORE_HOLD,
  input  logic        HOST_REQ,
  input  logic        HOST_WR,
  input  logic [1:0]  HOST_BEN,
  input  logic [15:0] HOST_ADDR,
  input  logic [15:0] HOST_DOUT,
  output logic        HOST_ACK,
  output logic [15:0] HOST_DIN,
  input  logic [15:0] MEM_DIN,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  output logic        MEM_RDN,
  output logic        MEM_WRN0,
  output logic        MEM_WRN1,
  output logic        MEM_DBUS_OEN
);

  // Elaboration-time guard on the legal parameter ranges
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_cfg
    $error("bus_arbiter: STROBE_CYCLES must be 1..15 and MAX_BURST 1..16");
  end

  localparam logic [STROBE_CNT_W-1:0] STROBE_LOAD = STROBE_CNT_W'(STROBE_CYCLES - 1);

  arb_state_e  state_q, state_d;
  logic        hold_q, hold_d;
  logic        ack_q, ack_d;
  logic [15:0] din_q, din_d;
  // Host request captured on every entry to SETUP so the bus stays stable
  logic [15:0] h_addr_q, h_addr_d;
  logic [15:0] h_dout_q, h_dout_d;
  logic        h_wr_q, h_wr_d;
  logic [1:0]  h_ben_q, h_ben_d;
  logic        tmr_load_s, tmr_dec_s, tmr_tc_s;
`ifdef HOST_BURST_EN
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);
  logic [BURST_CNT_W-1:0] burst_q, burst_d;
`endif

  arb_strobe_timer u_strobe_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (tmr_load_s),
    .load_val_i (STROBE_LOAD),
    .dec_i      (tmr_dec_s),
    .tc_o       (tmr_tc_s)
  );

  // Next-state logic for the ownership FSM and its registered outputs
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    ack_d      = 1'b0;
    din_d      = din_q;
    h_addr_d   = h_addr_q;
    h_dout_d   = h_dout_q;
    h_wr_d     = h_wr_q;
    h_ben_d    = h_ben_q;
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
`ifdef HOST_BURST_EN
    burst_d    = burst_q;
`endif
    case (state_q)
      ST_CORE: begin
        // Grant only at an instruction boundary; no mid-instruction preemption
        if (HOST_REQ && COMMIT) begin
          state_d  = ST_SETUP;
          hold_d   = 1'b1;
          h_addr_d = HOST_ADDR;
          h_dout_d = HOST_DOUT;
          h_wr_d   = HOST_WR;
          h_ben_d  = HOST_BEN;
`ifdef HOST_BURST_EN
          burst_d  = {BURST_CNT_W{1'b0}};
`endif
        end else begin
          hold_d = 1'b0;
        end
      end
      ST_SETUP: begin
        tmr_load_s = 1'b1;
        state_d    = ST_STROBE;
      end
      ST_STROBE: begin
        if (tmr_tc_s) begin
          // Last strobe cycle: sample read data and flag ACK for RECOVER
          state_d = ST_RECOVER;
          ack_d   = 1'b1;
          if (!h_wr_q) begin
            din_d = MEM_DIN;
          end else begin
            din_d = din_q;
          end
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_RECOVER: begin
`ifdef HOST_BURST_EN
        if (HOST_REQ && (burst_q < BURST_LAST)) begin
          state_d  = ST_SETUP;
          h_addr_d = HOST_ADDR;
          h_dout_d = HOST_DOUT;
          h_wr_d   = HOST_WR;
          h_ben_d  = HOST_BEN;
          burst_d  = burst_q + BURST_CNT_W'(1);
        end else begin
          state_d = ST_CORE;
          hold_d  = 1'b0;
        end
`else
        state_d = ST_CORE;
        hold_d  = 1'b0;
`endif
      end
      default: begin
        state_d = ST_CORE;
        hold_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without an ACK
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_CORE;
      hold_q   <= 1'b0;
      ack_q    <= 1'b0;
      din_q    <= 16'h0000;
      h_addr_q <= 16'h0000;
      h_dout_q <= 16'h0000;
      h_wr_q   <= 1'b0;
      h_ben_q  <= 2'b00;
`ifdef HOST_BURST_EN
      burst_q  <= {BURST_CNT_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      ack_q    <= ack_d;
      din_q    <= din_d;
      h_addr_q <= h_addr_d;
      h_dout_q <= h_dout_d;
      h_wr_q   <= h_wr_d;
      h_ben_q  <= h_ben_d;
`ifdef HOST_BURST_EN
      burst_q  <= burst_d;
`endif
    end
  end

  // Bus mux: strobes depend only on registered state, so ownership changes
  // happen while SETUP/RECOVER hold every strobe high
  always_comb begin
    MEM_ADDR     = CORE_ADDR;
    MEM_DOUT     = CORE_DOUT;
    MEM_RDN      = CORE_RDN;
    MEM_WRN0     = CORE_WRN0;
    MEM_WRN1     = CORE_WRN1;
    MEM_DBUS_OEN = CORE_DBUS_OEN;
    case (state_q)
      ST_CORE: begin
        MEM_ADDR = CORE_ADDR;
      end
      ST_SETUP, ST_RECOVER: begin
        MEM_ADDR     = h_addr_q;
        MEM_DOUT     = h_dout_q;
        MEM_RDN      = 1'b1;
        MEM_WRN0     = 1'b1;
        MEM_WRN1     = 1'b1;
        MEM_DBUS_OEN = ~h_wr_q;
      end
      ST_STROBE: begin
        MEM_ADDR     = h_addr_q;
        MEM_DOUT     = h_dout_q;
        MEM_RDN      = h_wr_q;
        MEM_WRN0     = ~(h_wr_q & h_ben_q[0]);
        MEM_WRN1     = ~(h_wr_q & h_ben_q[1]);
        MEM_DBUS_OEN = ~h_wr_q;
      end
      default: begin
        MEM_ADDR = CORE_ADDR;
      end
    endcase
  end

  assign CORE_HOLD = hold_q;
  assign HOST_ACK  = ack_q;
  assign HOST_DIN  = din_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Two instances share all inputs:
// u_dut2 (STROBE_CYCLES=2) for most scenarios and u_dut3 (STROBE_CYCLES=3)
// for the reset-during-strobe scenario. Build with +define+HOST_BURST_EN
// to exercise the burst scenario instead of the single-transfer fairness one.
module tb_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RESET, COMMIT, HOST_REQ, HOST_WR;
  logic        CORE_RDN, CORE_WRN0, CORE_WRN1, CORE_DBUS_OEN;
  logic [15:0] CORE_ADDR, CORE_DOUT, HOST_ADDR, HOST_DOUT, MEM_DIN;
  logic [1:0]  HOST_BEN;

  logic        hold2, ack2, mrdn2, mwrn0_2, mwrn1_2, moen2;
  logic [15:0] din2, maddr2, mdout2;
  logic        hold3, ack3, mrdn3, mwrn0_3, mwrn1_3, moen3;
  logic [15:0] din3, maddr3, mdout3;

  // {CORE_HOLD, HOST_ACK, MEM_RDN, MEM_WRN0, MEM_WRN1, MEM_DBUS_OEN}
  wire [5:0] ctl2 = {hold2, ack2, mrdn2, mwrn0_2, mwrn1_2, moen2};
  wire [5:0] ctl3 = {hold3, ack3, mrdn3, mwrn0_3, mwrn1_3, moen3};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  bus_arbiter #(.STROBE_CYCLES(2), .MAX_BURST(4)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .COMMIT(COMMIT),
    .CORE_ADDR(CORE_ADDR), .CORE_DOUT(CORE_DOUT), .CORE_RDN(CORE_RDN),
    .CORE_WRN0(CORE_WRN0), .CORE_WRN1(CORE_WRN1), .CORE_DBUS_OEN(CORE_DBUS_OEN),
    .CORE_HOLD(hold2), .HOST_REQ(HOST_REQ), .HOST_WR(HOST_WR), .HOST_BEN(HOST_BEN),
    .HOST_ADDR(HOST_ADDR), .HOST_DOUT(HOST_DOUT), .HOST_ACK(ack2), .HOST_DIN(din2),
    .MEM_DIN(MEM_DIN), .MEM_ADDR(maddr2), .MEM_DOUT(mdout2), .MEM_RDN(mrdn2),
    .MEM_WRN0(mwrn0_2), .MEM_WRN1(mwrn1_2), .MEM_DBUS_OEN(moen2)
  );

  bus_arbiter #(.STROBE_CYCLES(3), .MAX_BURST(4)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .COMMIT(COMMIT),
    .CORE_ADDR(CORE_ADDR), .CORE_DOUT(CORE_DOUT), .CORE_RDN(CORE_RDN),
    .CORE_WRN0(CORE_WRN0), .CORE_WRN1(CORE_WRN1), .CORE_DBUS_OEN(CORE_DBUS_OEN),
    .CORE_HOLD(hold3), .HOST_REQ(HOST_REQ), .HOST_WR(HOST_WR), .HOST_BEN(HOST_BEN),
    .HOST_ADDR(HOST_ADDR), .HOST_DOUT(HOST_DOUT), .HOST_ACK(ack3), .HOST_DIN(din3),
    .MEM_DIN(MEM_DIN), .MEM_ADDR(maddr3), .MEM_DOUT(mdout3), .MEM_RDN(mrdn3),
    .MEM_WRN0(mwrn0_3), .MEM_WRN1(mwrn1_3), .MEM_DBUS_OEN(moen3)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle(2);
    CORE_ADDR = 16'hABCD;
    #1;
    n_tests++;
    if (ctl2 !== 6'b001111) begin n_fail++; $display("FAIL reset_ctl2 got %b exp %b", ctl2, 6'b001111); end
    n_tests++;
    if (ctl3 !== 6'b001111) begin n_fail++; $display("FAIL reset_ctl3 got %b exp %b", ctl3, 6'b001111); end
    n_tests++;
    if (din2 !== 16'h0000) begin n_fail++; $display("FAIL reset_din got %h exp %h", din2, 16'h0000); end
    n_tests++;
    if (maddr2 !== 16'hABCD) begin n_fail++; $display("FAIL reset_passthru got %h exp %h", maddr2, 16'hABCD); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    CORE_ADDR = 16'h1234; CORE_RDN = 1'b0; CORE_DOUT = 16'h5A5A;
    #1;
    n_tests++;
    if ({maddr2, mrdn2, mdout2} !== {16'h1234, 1'b0, 16'h5A5A}) begin
      n_fail++; $display("FAIL pass_same_cycle got %h/%b/%h exp 1234/0/5a5a", maddr2, mrdn2, mdout2);
    end
    CORE_ADDR = 16'h5678; CORE_WRN1 = 1'b0; CORE_DBUS_OEN = 1'b0;
    #1;
    n_tests++;
    if ({maddr2, mwrn1_2, moen2} !== {16'h5678, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL pass_comb got %h/%b/%b exp 5678/0/0", maddr2, mwrn1_2, moen2);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (hold2 !== 1'b0) begin n_fail++; $display("FAIL pass_hold got %b exp 0", hold2); end
    end
    CORE_RDN = 1'b1; CORE_WRN1 = 1'b1; CORE_DBUS_OEN = 1'b1; CORE_ADDR = 16'h4000;
  endtask

  task automatic test_host_read();
    HOST_REQ = 1'b1; HOST_WR = 1'b0; HOST_ADDR = 16'h0100; MEM_DIN = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({hold2, maddr2} !== {1'b0, 16'h4000}) begin
        n_fail++; $display("FAIL rd_no_grant got %b/%h exp 0/4000", hold2, maddr2);
      end
    end
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    n_tests++;
    if ({ctl2, maddr2} !== {6'b101111, 16'h0100}) begin
      n_fail++; $display("FAIL rd_setup got %b/%h exp 101111/0100", ctl2, maddr2);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({ctl2, maddr2} !== {6'b100111, 16'h0100}) begin
        n_fail++; $display("FAIL rd_strobe got %b/%h exp 100111/0100", ctl2, maddr2);
      end
    end
    tick();
    n_tests++;
    if ({ctl2, din2} !== {6'b111111, 16'hBEEF}) begin
      n_fail++; $display("FAIL rd_recover got %b/%h exp 111111/beef", ctl2, din2);
    end
    HOST_REQ = 1'b0; MEM_DIN = 16'h0000;
    tick();
    n_tests++;
    if ({ctl2, din2, maddr2} !== {6'b001111, 16'hBEEF, 16'h4000}) begin
      n_fail++; $display("FAIL rd_release got %b/%h/%h exp 001111/beef/4000", ctl2, din2, maddr2);
    end
    idle(3);
  endtask

  task automatic test_byte_write();
    HOST_REQ = 1'b1; HOST_WR = 1'b1; HOST_BEN = 2'b10; HOST_DOUT = 16'hAA55;
    HOST_ADDR = 16'h0200; COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    n_tests++;
    if ({ctl2, mdout2, maddr2} !== {6'b101110, 16'hAA55, 16'h0200}) begin
      n_fail++; $display("FAIL wr_setup got %b/%h/%h exp 101110/aa55/0200", ctl2, mdout2, maddr2);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({ctl2, mdout2} !== {6'b101100, 16'hAA55}) begin
        n_fail++; $display("FAIL wr_strobe got %b/%h exp 101100/aa55", ctl2, mdout2);
      end
    end
    tick();
    n_tests++;
    if ({ctl2, din2} !== {6'b111110, 16'hBEEF}) begin
      n_fail++; $display("FAIL wr_recover got %b/%h exp 111110/beef", ctl2, din2);
    end
    HOST_REQ = 1'b0;
    tick();
    n_tests++;
    if (hold2 !== 1'b0) begin n_fail++; $display("FAIL wr_release got %b exp 0", hold2); end
    idle(3);
  endtask

  task automatic test_zero_ben();
    HOST_REQ = 1'b1; HOST_WR = 1'b1; HOST_BEN = 2'b00; HOST_ADDR = 16'h0300; COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if ({ack2, mrdn2, mwrn0_2, mwrn1_2} !== {(i == 4), 3'b111}) begin
        n_fail++; $display("FAIL zben_cycle%0d got %b exp %b", i, {ack2, mrdn2, mwrn0_2, mwrn1_2}, {(i == 4), 3'b111});
      end
      if (i == 4) HOST_REQ = 1'b0;
      tick();
    end
    idle(3);
  endtask

  task automatic test_reset_mid_strobe();
    int acks;
    HOST_REQ = 1'b1; HOST_WR = 1'b1; HOST_BEN = 2'b11; HOST_DOUT = 16'h1111;
    HOST_ADDR = 16'h0400; COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    idle(2);
    n_tests++;
    if (ctl3 !== 6'b101000) begin n_fail++; $display("FAIL rst_strobe2 got %b exp 101000", ctl3); end
    RESET = 1'b1; HOST_REQ = 1'b0;
    tick();
    RESET = 1'b0;
    n_tests++;
    if ({ctl3, maddr3} !== {6'b001111, 16'h4000}) begin
      n_fail++; $display("FAIL rst_abort got %b/%h exp 001111/4000", ctl3, maddr3);
    end
    n_tests++;
    if (din2 !== 16'h0000) begin n_fail++; $display("FAIL rst_din_clear got %h exp 0000", din2); end
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      acks += int'(ack2) + int'(ack3);
      tick();
    end
    n_tests++;
    if (acks !== 0) begin n_fail++; $display("FAIL rst_no_ack got %0d exp 0", acks); end
  endtask

  task automatic test_fairness();
    int c;
    int low_cycles;
    HOST_REQ = 1'b1; HOST_WR = 1'b0; HOST_ADDR = 16'h0500; MEM_DIN = 16'h1357; COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    for (c = 0; c < 10 && !ack2; c++) tick();
    n_tests++;
    if ({ack2, din2} !== {1'b1, 16'h1357}) begin
      n_fail++; $display("FAIL fair_ack1 got %b/%h exp 1/1357", ack2, din2);
    end
    low_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (hold2 === 1'b0) low_cycles++;
    end
    n_tests++;
    if (low_cycles !== 4) begin n_fail++; $display("FAIL fair_wait_commit got %0d exp 4", low_cycles); end
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    n_tests++;
    if (hold2 !== 1'b1) begin n_fail++; $display("FAIL fair_regrant got %b exp 1", hold2); end
    for (c = 0; c < 10 && !ack2; c++) tick();
    n_tests++;
    if (ack2 !== 1'b1) begin n_fail++; $display("FAIL fair_ack2 got %b exp 1", ack2); end
    HOST_REQ = 1'b0;
    idle(6);
  endtask

  task automatic test_burst();
    int acks1, acks2, c;
    acks1 = 0; acks2 = 0;
    HOST_REQ = 1'b1; HOST_WR = 1'b0; HOST_ADDR = 16'h0600; MEM_DIN = 16'h2468; COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    for (c = 0; c < 40 && hold2; c++) begin
      if (ack2) acks1++;
      tick();
    end
    n_tests++;
    if ({hold2, acks1} !== {1'b0, 32'd4}) begin
      n_fail++; $display("FAIL burst_first got hold %b acks %0d exp hold 0 acks 4", hold2, acks1);
    end
    idle(2);
    n_tests++;
    if (hold2 !== 1'b0) begin n_fail++; $display("FAIL burst_wait_commit got %b exp 0", hold2); end
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    for (c = 0; c < 40 && hold2; c++) begin
      if (ack2) begin
        acks2++;
        if (acks1 + acks2 >= 6) HOST_REQ = 1'b0;
      end
      tick();
    end
    n_tests++;
    if ({hold2, acks2} !== {1'b0, 32'd2}) begin
      n_fail++; $display("FAIL burst_second got hold %b acks %0d exp hold 0 acks 2", hold2, acks2);
    end
    HOST_REQ = 1'b0;
    idle(12);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    RESET = 1'b1; COMMIT = 1'b0; HOST_REQ = 1'b0; HOST_WR = 1'b0; HOST_BEN = 2'b00;
    CORE_ADDR = 16'h0000; CORE_DOUT = 16'h0000; CORE_RDN = 1'b1; CORE_WRN0 = 1'b1;
    CORE_WRN1 = 1'b1; CORE_DBUS_OEN = 1'b1; HOST_ADDR = 16'h0000; HOST_DOUT = 16'h0000;
    MEM_DIN = 16'h0000;
    test_reset();
    test_passthrough();
    test_host_read();
    test_byte_write();
    test_zero_ben();
    test_reset_mid_strobe();
`ifdef HOST_BURST_EN
    test_burst();
`else
    test_fairness();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
